// File: rtl/sprite_pkg.sv
// sprite_pkg: shared types and helpers for the maze sprite mover and the
// sprite probe decoder (direction encoding, mask bit order, mover states).
package sprite_pkg;

    // Direction encoding, identical to the heading output: 0=L 1=U 2=R 3=D.
    typedef enum logic [1:0] {
        DIR_L = 2'd0,
        DIR_U = 2'd1,
        DIR_R = 2'd2,
        DIR_D = 2'd3
    } dir_t;

    // Bit positions inside every 4-bit {left,up,right,down} mask.
    localparam int MASK_L = 3;
    localparam int MASK_U = 2;
    localparam int MASK_R = 1;
    localparam int MASK_D = 0;

    typedef enum logic [0:0] {
        STOPPED = 1'b0,
        MOVING  = 1'b1
    } mover_state_t;

    // Mask bit that corresponds to a direction (L is the MSB, D the LSB).
    function automatic logic [1:0] mask_bit(input dir_t d);
        return 2'd3 - 2'(d);
    endfunction

    // True when exactly one request bit is set.
    function automatic logic is_one_hot(input logic [3:0] v);
        return (v != 4'b0000) && ((v & (v - 4'b0001)) == 4'b0000);
    endfunction

    // Convert a one-hot {left,up,right,down} request into a direction.
    function automatic dir_t onehot_to_dir(input logic [3:0] v);
        dir_t d;
        case (v)
            4'b1000: d = DIR_L;
            4'b0100: d = DIR_U;
            4'b0010: d = DIR_R;
            4'b0001: d = DIR_D;
            default: d = DIR_L;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/sprite_probe.sv
// sprite_probe: combinational sprite bounds decode. Produces the sprite fill
// for the current scan pixel and four single-pixel wall probe strobes sitting
// one pixel outside each sprite edge. Shared with the ghost renderers.
module sprite_probe
    import sprite_pkg::*;
#(
    parameter int SPRITE_W = 17,
    parameter int OFF_H    = 274,
    parameter int OFF_V    = 58
) (
    input  logic [9:0] posX,
    input  logic [9:0] posY,
    input  logic [9:0] hCount,
    input  logic [9:0] vCount,
    output logic       spriteFill,
    output logic [3:0] probe
);

    localparam logic [11:0] HALF_C = 12'((SPRITE_W - 1) / 2);

    // 12-bit screen-space coordinates so centre-half never underflows.
    logic [11:0] xc_s;
    logic [11:0] yc_s;
    logic [11:0] h_s;
    logic [11:0] v_s;
    logic        h_in_s;
    logic        v_in_s;

    // Span tests and independent edge probes (no priority between them).
    always_comb begin
        xc_s   = 12'(OFF_H) + {2'b00, posX};
        yc_s   = 12'(OFF_V) + {2'b00, posY};
        h_s    = {2'b00, hCount};
        v_s    = {2'b00, vCount};
        h_in_s = ((h_s + HALF_C) >= xc_s) && (h_s <= (xc_s + HALF_C));
        v_in_s = ((v_s + HALF_C) >= yc_s) && (v_s <= (yc_s + HALF_C));
        probe          = 4'b0000;
        probe[MASK_L]  = ((h_s + HALF_C + 12'd1) == xc_s) && v_in_s;
        probe[MASK_R]  = (h_s == (xc_s + HALF_C + 12'd1)) && v_in_s;
        probe[MASK_U]  = ((v_s + HALF_C + 12'd1) == yc_s) && h_in_s;
        probe[MASK_D]  = (v_s == (yc_s + HALF_C + 12'd1)) && h_in_s;
        spriteFill     = h_in_s && v_in_s;
    end

endmodule

// File: rtl/sprite_mover.sv
// sprite_mover: one-pixel-per-tick mover for a single maze sprite. Wall
// probes gathered during the scan are folded into a blocked-direction mask
// that is snapshotted on every step tick; a one-deep request buffer allows
// pre-turning into corridors.
// Optional build macro TUNNEL_WRAP_EN: horizontal moves wrap between 0 and
// ARENA_W instead of saturating (Y always saturates).
module sprite_mover
    import sprite_pkg::*;
#(
    parameter int SPRITE_W = 17,
    parameter int ARENA_W  = 380,
    parameter int ARENA_H  = 432,
    parameter int X_INI    = 190,
    parameter int Y_INI    = 318,
    parameter int OFF_H    = 274,
    parameter int OFF_V    = 58,
    parameter int STEP_DIV = 10000,
    parameter int CNT_W    = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic [3:0] req_dir,
    input  logic [9:0] hCount,
    input  logic [9:0] vCount,
    input  logic       wallFill,
    output logic       spriteFill,
    output logic [3:0] cgDirections,
    output logic [9:0] posX,
    output logic [9:0] posY,
    output logic [1:0] heading,
    output logic       moving,
    output logic       step
);

    localparam logic [0:0] ST_STOPPED = STOPPED;
    localparam logic [0:0] ST_MOVING  = MOVING;
    localparam logic [9:0] AW_C       = 10'(ARENA_W);
    localparam logic [9:0] AH_C       = 10'(ARENA_H);
    localparam logic [9:0] XI_C       = 10'(X_INI);
    localparam logic [9:0] YI_C       = 10'(Y_INI);

    logic [CNT_W-1:0] counter_r;
    logic             tick_s;
    logic [3:0]       probe_s;
    logic [3:0]       hit_s;
    logic [3:0]       acc_r;
    logic [3:0]       mask_s;
    logic [3:0]       cg_r;
    logic             pend_valid_r;
    dir_t             pend_dir_r;
    dir_t             heading_r;
    logic [0:0]       state_r;
    logic [9:0]       pos_x_r;
    logic [9:0]       pos_y_r;
    logic             step_r;
    logic             take_s;
    logic             cont_s;
    logic             do_move_s;
    dir_t             move_dir_s;
    logic [9:0]       nx_s;
    logic [9:0]       ny_s;
    logic             changed_s;

    // One pixel along d; the flag reports whether the position really changed.
    function automatic logic [20:0] move_pos(input dir_t d, input logic [9:0] x,
                                             input logic [9:0] y);
        logic [9:0] nx;
        logic [9:0] ny;
        logic       ch;
        nx = x;
        ny = y;
        ch = 1'b0;
        case (d)
            DIR_L: begin
                if (x != 10'd0) begin
                    nx = x - 10'd1;
                    ch = 1'b1;
                end else begin
`ifdef TUNNEL_WRAP_EN
                    nx = AW_C;
                    ch = 1'b1;
`else
                    nx = x;
                    ch = 1'b0;
`endif
                end
            end
            DIR_R: begin
                if (x < AW_C) begin
                    nx = x + 10'd1;
                    ch = 1'b1;
                end else begin
`ifdef TUNNEL_WRAP_EN
                    nx = 10'd0;
                    ch = 1'b1;
`else
                    nx = x;
                    ch = 1'b0;
`endif
                end
            end
            DIR_U: begin
                if (y != 10'd0) begin
                    ny = y - 10'd1;
                    ch = 1'b1;
                end else begin
                    ny = y;
                    ch = 1'b0;
                end
            end
            DIR_D: begin
                if (y < AH_C) begin
                    ny = y + 10'd1;
                    ch = 1'b1;
                end else begin
                    ny = y;
                    ch = 1'b0;
                end
            end
            default: begin
                nx = x;
                ny = y;
                ch = 1'b0;
            end
        endcase
        return {ch, nx, ny};
    endfunction

    sprite_probe #(
        .SPRITE_W (SPRITE_W),
        .OFF_H    (OFF_H),
        .OFF_V    (OFF_V)
    ) u_probe (
        .posX       (pos_x_r),
        .posY       (pos_y_r),
        .hCount     (hCount),
        .vCount     (vCount),
        .spriteFill (spriteFill),
        .probe      (probe_s)
    );

    assign tick_s = enable && (counter_r == CNT_W'(STEP_DIV - 1));
    assign hit_s  = probe_s & {4{wallFill}};
    // The mask seen on a tick includes a wall hit on that very cycle.
    assign mask_s = acc_r & ~hit_s;

    // Move decision: a valid free pending turn beats continuing straight.
    always_comb begin
        take_s     = 1'b0;
        cont_s     = 1'b0;
        do_move_s  = 1'b0;
        move_dir_s = heading_r;
        take_s     = pend_valid_r && mask_s[mask_bit(pend_dir_r)];
        cont_s     = (state_r == ST_MOVING) && mask_s[mask_bit(heading_r)];
        if (take_s) begin
            move_dir_s = pend_dir_r;
            do_move_s  = 1'b1;
        end else if (cont_s) begin
            move_dir_s = heading_r;
            do_move_s  = 1'b1;
        end else begin
            move_dir_s = heading_r;
            do_move_s  = 1'b0;
        end
        {changed_s, nx_s, ny_s} = move_pos(move_dir_s, pos_x_r, pos_y_r);
    end

    // Step divider: counts only while enabled, wraps to 0 on the tick.
    always_ff @(posedge clk) begin
        if (reset) begin
            counter_r <= {CNT_W{1'b0}};
        end else if (tick_s) begin
            counter_r <= {CNT_W{1'b0}};
        end else if (enable) begin
            counter_r <= counter_r + CNT_W'(1);
        end else begin
            counter_r <= counter_r;
        end
    end

    // Probe accumulator and per-tick snapshot of the free-direction mask.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_r <= 4'b1111;
            cg_r  <= 4'b1111;
        end else if (tick_s) begin
            acc_r <= 4'b1111;
            cg_r  <= mask_s;
        end else begin
            acc_r <= mask_s;
            cg_r  <= cg_r;
        end
    end

    // Request buffer: one-hot requests replace pending; a taken turn clears it.
    always_ff @(posedge clk) begin
        if (reset) begin
            pend_valid_r <= 1'b0;
            pend_dir_r   <= DIR_L;
        end else if (tick_s && take_s) begin
            pend_valid_r <= 1'b0;
            pend_dir_r   <= pend_dir_r;
        end else if (is_one_hot(req_dir)) begin
            pend_valid_r <= 1'b1;
            pend_dir_r   <= onehot_to_dir(req_dir);
        end else begin
            pend_valid_r <= pend_valid_r;
            pend_dir_r   <= pend_dir_r;
        end
    end

    // Mover state, heading, position and step pulse, updated only on ticks.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= ST_STOPPED;
            heading_r <= DIR_L;
            pos_x_r   <= XI_C;
            pos_y_r   <= YI_C;
            step_r    <= 1'b0;
        end else if (tick_s && do_move_s) begin
            state_r   <= ST_MOVING;
            heading_r <= move_dir_s;
            pos_x_r   <= nx_s;
            pos_y_r   <= ny_s;
            step_r    <= changed_s;
        end else if (tick_s) begin
            state_r   <= ST_STOPPED;
            heading_r <= heading_r;
            pos_x_r   <= pos_x_r;
            pos_y_r   <= pos_y_r;
            step_r    <= 1'b0;
        end else begin
            state_r   <= state_r;
            heading_r <= heading_r;
            pos_x_r   <= pos_x_r;
            pos_y_r   <= pos_y_r;
            step_r    <= 1'b0;
        end
    end

    assign cgDirections = cg_r;
    assign posX         = pos_x_r;
    assign posY         = pos_y_r;
    assign heading      = 2'(heading_r);
    assign moving       = (state_r == ST_MOVING);
    assign step         = step_r;

endmodule

// File: doc/sprite_mover.md
Name: sprite_mover

Overview:
- Parametrised grid-free mover for one maze sprite (Pac-Man or a ghost), instanced once per sprite.
- Advances the sprite position one pixel per step tick.
- Derives blocked directions from single-pixel wall probes gathered during VGA scan.
- Buffers the player's last direction request for cornering, and drives a sprite fill plus a blocked-direction mask to the renderer and game logic.

Parameters:
- SPRITE_W, 17: sprite edge in pixels; odd; half = (SPRITE_W-1)/2.
- ARENA_W, 380: maximum centre X, arena coordinates.
- ARENA_H, 432: maximum centre Y.
- X_INI, 190: centre X after reset.
- Y_INI, 318: centre Y after reset.
- OFF_H, 274: hCount of arena column 0 (screen offset 130 + blanking 144).
- OFF_V, 58: vCount of arena row 0 (24 + 34).
- STEP_DIV, 10000: clk cycles per step tick; must be >= 2.
- CNT_W, 16: step counter width; 2^CNT_W > STEP_DIV.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- enable  in  1  game running; 0 freezes the counter and position
- req_dir  in  4  {left,up,right,down} raw request, any combination
- hCount  in  10  current scan column
- vCount  in  10  current scan row
- wallFill  in  1  current scan pixel is wall
- spriteFill  out  1  current scan pixel lies inside the sprite
- cgDirections  out  4  {left,up,right,down}, 1 = free, snapshot from last tick
- posX  out  10  sprite centre X
- posY  out  10  sprite centre Y
- heading  out  2  0 = L, 1 = U, 2 = R, 3 = D
- moving  out  1  1 while heading is being executed
- step  out  1  one-cycle pulse on each tick that changed the position

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high on port reset. All state updates on posedge clk.
- Reset values: posX = X_INI, posY = Y_INI, counter = 0, probe accumulator = 4'b1111, cgDirections = 4'b1111, pending = none, heading = 0, moving = 0, step = 0.
- Counter: when enable = 1, increments each cycle. tick = enable && counter == STEP_DIV-1. On tick the counter returns to 0.
- Probes (combinational, each compared at centre ±half):
  - left: hCount == centre-half-1 with vCount inside the sprite span.
  - up: vCount == centre-half-1 with hCount inside the span.
  - right and down mirror left and up.
  - All four probes are evaluated independently; there is no priority chain.
  - When probe_i && wallFill, accumulator bit i clears.
- Tick snapshot: cgDirections <= accumulator AND this cycle's probe result. The accumulator then returns to 4'b1111.
- Request buffer:
  - A one-hot req_dir latches as pending and is held until executed or replaced.
  - Multi-hot or zero requests leave pending unchanged.
- State machine, evaluated only on tick, using the snapshot mask m = accumulator AND this cycle's probe:
  - STOPPED: if pending is valid and m[pending] = 1, then heading <= pending, pending is cleared, state becomes MOVING, and the sprite moves one pixel.
  - MOVING, pending turn: if pending is valid and m[pending] = 1, take the turn as above.
  - MOVING, continue: otherwise, if m[heading] = 1, move one pixel along heading and keep pending.
  - MOVING, stop: otherwise go to STOPPED with no move.
  - moving = (state == MOVING).
  - step = 1 on the cycle after any tick that moved the sprite.
- Arithmetic:
  - Positions are 10-bit unsigned.
  - Decrementing from 0 saturates at 0; there is no underflow wrap.
  - X saturates at ARENA_W and Y saturates at ARENA_H. A saturated move does not pulse step.
- spriteFill: combinational, true for OFF+pos-half <= count <= OFF+pos+half on both axes.
- enable = 0 mid-step: the counter holds its value; probes still accumulate; the request buffer still latches.
- reset asserted during a tick: reset wins and no move is applied.

Optional Feature:
- Macro TUNNEL_WRAP_EN.
- Defined: horizontal moves wrap instead of saturating.
  - Left from X = 0 gives X = ARENA_W; right from ARENA_W gives 0; step pulses.
  - Y still saturates.
- Undefined: both axes saturate as described in Behaviour.

Decomposition:
- Package sprite_pkg:
  - dir_t enum (L, U, R, D), with 2-bit encoding matching heading.
  - 4-bit mask bit-order constants.
  - mover_state_t enum (STOPPED, MOVING).
- Sub-module sprite_probe: purely combinational bounds and probe decode (spriteFill plus four probe strobes). It is reused by ghost renderers.

Test Plan (STEP_DIV = 4, no walls unless stated):
- Reset, then hold req_dir = 4'b0010 (right) for 3 ticks -> posX = 193, posY = 318, heading = 2, three step pulses.
- Wall pixel on the right probe column (hCount = 274+190+9) during the first period, req right -> no move, moving = 0, cgDirections = 4'b1101.
- Heading right, pulse up for one cycle while up is blocked -> sprite keeps moving right; once up clears, the next tick turns up and posY decrements.
- Drive the sprite to X = 0 with left held -> posX stays 0 and no step pulse; with TUNNEL_WRAP_EN -> posX = 380 and step = 1.
- Assert reset for one cycle mid-movement with the counter at 3 -> next cycle posX = 190, posY = 318, state STOPPED, cgDirections = 4'b1111.
- req_dir = 4'b1100 (multi-hot) from STOPPED -> pending unchanged, no movement.
